// File: rtl/branch_cmp_pipe.sv
// Two-stage pipelined branch comparator with valid/ready handshake and flush.
// Optional performance counters are enabled by defining BRANCH_CMP_PERF_EN.
module branch_cmp_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_d1,
  input  logic [WIDTH-1:0] in_d2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [7:0]       out_flags,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
`ifdef BRANCH_CMP_PERF_EN
  ,
  output logic [31:0]      perf_total,
  output logic [31:0]      perf_taken
`endif
);

  typedef enum logic [3:0] {
    OP_EQ  = 4'd0,
    OP_NE  = 4'd1,
    OP_LTZ = 4'd2,
    OP_LEZ = 4'd3,
    OP_GTZ = 4'd4,
    OP_GEZ = 4'd5,
    OP_LT  = 4'd6,
    OP_LTU = 4'd7,
    OP_GE  = 4'd8,
    OP_GEU = 4'd9
  } op_e;

  logic             s1_valid_r;
  logic [3:0]       s1_op_r;
  logic [WIDTH-1:0] s1_d1_r;
  logic [WIDTH-1:0] s1_d2_r;
  logic [TAG_W-1:0] s1_tag_r;

  logic             s2_valid_r;
  logic [7:0]       s2_flags_r;
  logic             s2_taken_r;
  logic             s2_illegal_r;
  logic [TAG_W-1:0] s2_tag_r;

  logic s2_free_s;
  logic s1_adv_s;
  logic accept_s;
  logic eq_s, ltz_s, a_zero_s, lt_s, ltu_s;
  logic [7:0] flags_s;
  logic taken_s;
  logic illegal_s;

  assign s2_free_s = !s2_valid_r || out_ready;
  assign s1_adv_s  = s1_valid_r && s2_free_s;
  // Flush and reset both block acceptance; flush wins over any handshake.
  assign in_ready  = reset && !flush && (!s1_valid_r || s2_free_s);
  assign accept_s  = in_valid && in_ready;

  // Native signed/unsigned compares keep the decision inside WIDTH bits.
  assign eq_s     = (s1_d1_r == s1_d2_r);
  assign ltz_s    = s1_d1_r[WIDTH-1];
  assign a_zero_s = (s1_d1_r == {WIDTH{1'b0}});
  assign lt_s     = ($signed(s1_d1_r) < $signed(s1_d2_r));
  assign ltu_s    = (s1_d1_r < s1_d2_r);

  // Flag vector and opcode-selected branch condition from the S1 registers.
  always_comb begin
    flags_s   = 8'h00;
    taken_s   = 1'b0;
    illegal_s = 1'b0;
    flags_s   = {!ltu_s, ltu_s, lt_s, !ltz_s, (!ltz_s && !a_zero_s),
                 (ltz_s || a_zero_s), ltz_s, eq_s};
    case (s1_op_r)
      OP_EQ:   taken_s = flags_s[0];
      OP_NE:   taken_s = !flags_s[0];
      OP_LTZ:  taken_s = flags_s[1];
      OP_LEZ:  taken_s = flags_s[2];
      OP_GTZ:  taken_s = flags_s[3];
      OP_GEZ:  taken_s = flags_s[4];
      OP_LT:   taken_s = flags_s[5];
      OP_LTU:  taken_s = flags_s[6];
      OP_GE:   taken_s = !flags_s[5];
      OP_GEU:  taken_s = flags_s[7];
      default: illegal_s = 1'b1;
    endcase
  end

  // S1 operand register: a new accept may overwrite an entry leaving this cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid_r <= 1'b0;
      s1_op_r    <= 4'd0;
      s1_d1_r    <= {WIDTH{1'b0}};
      s1_d2_r    <= {WIDTH{1'b0}};
      s1_tag_r   <= {TAG_W{1'b0}};
    end else if (flush) begin
      s1_valid_r <= 1'b0;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_op_r    <= in_op;
      s1_d1_r    <= in_d1;
      s1_d2_r    <= in_d2;
      s1_tag_r   <= in_tag;
    end else if (s1_adv_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // S2 result register drives all outputs and holds while stalled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s2_valid_r   <= 1'b0;
      s2_flags_r   <= 8'h00;
      s2_taken_r   <= 1'b0;
      s2_illegal_r <= 1'b0;
      s2_tag_r     <= {TAG_W{1'b0}};
    end else if (flush) begin
      s2_valid_r <= 1'b0;
    end else if (s1_adv_s) begin
      s2_valid_r   <= 1'b1;
      s2_flags_r   <= flags_s;
      s2_taken_r   <= taken_s && !illegal_s;
      s2_illegal_r <= illegal_s;
      s2_tag_r     <= s1_tag_r;
    end else if (out_ready) begin
      s2_valid_r <= 1'b0;
    end else begin
      s2_valid_r <= s2_valid_r;
    end
  end

  assign out_valid   = s2_valid_r;
  assign out_taken   = s2_taken_r;
  assign out_flags   = s2_flags_r;
  assign out_illegal = s2_illegal_r;
  assign out_tag     = s2_tag_r;

`ifdef BRANCH_CMP_PERF_EN
  logic [31:0] perf_total_r;
  logic [31:0] perf_taken_r;

  // Saturating handshake counters; a flush cycle never counts as a handshake.
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_total_r <= 32'd0;
      perf_taken_r <= 32'd0;
    end else if (!flush && s2_valid_r && out_ready) begin
      if (perf_total_r != 32'hFFFF_FFFF) begin
        perf_total_r <= perf_total_r + 32'd1;
      end
      if (s2_taken_r && (perf_taken_r != 32'hFFFF_FFFF)) begin
        perf_taken_r <= perf_taken_r + 32'd1;
      end
    end else begin
      perf_total_r <= perf_total_r;
      perf_taken_r <= perf_taken_r;
    end
  end

  assign perf_total = perf_total_r;
  assign perf_taken = perf_taken_r;
`endif

endmodule
